// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding memory reads, a small instruction
// FIFO towards decode, PC back-pressure and jump flush.
module if_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic [2:0]  hold_flag_i,
  output logic        pc_hold_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        id_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t         state, state_next;
  logic [31:0]    req_addr;
  logic [31:0]    fifo_inst [DEPTH];
  logic [31:0]    fifo_addr [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, occ_next;
  logic           push, pop, stall, issue;

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o & id_ready_i;
  assign push         = (state == WAIT) & mem_rvalid_i & ~jump_flag_i;
  assign occ_next     = count + CW'(push) - CW'(pop);
  assign stall        = (hold_flag_i >= 3'b010);

  // A response arriving this cycle frees the single slot, so a new request can
  // go out in the same cycle (back-to-back fetch with 1-cycle memory).
  assign issue = rst & ~jump_flag_i & ~stall
               & ((state == IDLE) | mem_rvalid_i)
               & (occ_next < CW'(DEPTH));

  assign mem_req_o     = issue;
  assign mem_addr_o    = pc_i;
  assign pc_hold_req_o = ~issue & ~jump_flag_i;

  assign inst_o      = inst_valid_o ? fifo_inst[rd_ptr] : NOP_INST;
  assign inst_addr_o = inst_valid_o ? fifo_addr[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    if (jump_flag_i) begin
      // An in-flight request with no response yet must have its data discarded.
      if ((state == WAIT || state == DROP) && !mem_rvalid_i) state_next = DROP;
      else                                                    state_next = IDLE;
    end else if (issue) begin
      state_next = WAIT;
    end else if (mem_rvalid_i && (state == WAIT || state == DROP)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      req_addr <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_next;
      if (issue) req_addr <= pc_i;
      if (jump_flag_i) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= occ_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_inst[wr_ptr] <= mem_rdata_i;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios followed by a randomized phase, all checked cycle by cycle
// against a transaction-level model of the fetch stage and a latency memory.
module tb_if_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, jump_flag_i, mem_rvalid_i, id_ready_i;
  logic [2:0]  hold_flag_i;
  logic [31:0] pc_i, mem_rdata_i;
  logic        pc_hold_req_o, mem_req_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o, inst_addr_o;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
    .hold_flag_i(hold_flag_i), .pc_hold_req_o(pc_hold_req_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .id_ready_i(id_ready_i)
  );

  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, req_count = 0;

  // Reference model: buffered {addr,inst} pairs, one optional in-flight request.
  logic [63:0] q[$];
  logic [31:0] popped[$];
  bit          outstanding = 0, discard = 0;
  logic [31:0] req_addr_m = '0, jump_target = '0;
  logic [31:0] resp_at[int];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are checked
  // on the falling edge; the model advances just after the next rising edge.
  task automatic cycle();
    bit rv, pop, push, exp_issue, exp_hold;
    int occ;
    logic [31:0] rdata;
    rv = resp_at.exists(cyc);
    rdata = rv ? resp_at[cyc] : $urandom;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    @(negedge clk);
    pop  = (q.size() != 0) && id_ready_i;
    push = outstanding && !discard && rv && !jump_flag_i;
    occ  = q.size() + int'(push) - int'(pop);
    exp_issue = rst && !jump_flag_i && (hold_flag_i < 3'b010)
              && (!outstanding || rv) && (occ < DEPTH);
    exp_hold  = !exp_issue && !jump_flag_i;
    chk("inst_valid", inst_valid_o, q.size() != 0);
    chk("inst",       inst_o,       (q.size() != 0) ? q[0][31:0]  : NOP);
    chk("inst_addr",  inst_addr_o,  (q.size() != 0) ? q[0][63:32] : 32'h0);
    chk("mem_req",    mem_req_o,    exp_issue);
    chk("pc_hold",    pc_hold_req_o, exp_hold);
    chk("mem_addr",   mem_addr_o,   pc_i);
    if (mem_req_o) req_count++;
    @(posedge clk);
    #1;
    if (rv) resp_at.delete(cyc);
    if (!rst) begin
      q.delete();
      outstanding = 0;
      discard     = 0;
      req_addr_m  = '0;
    end else if (jump_flag_i) begin
      q.delete();
      if (outstanding && !rv) discard = 1;
      else begin outstanding = 0; discard = 0; end
      pc_i = jump_target;
    end else begin
      if (pop) begin
        popped.push_back(q[0][63:32]);
        void'(q.pop_front());
      end
      if (push) q.push_back({req_addr_m, rdata});
      if (rv) begin outstanding = 0; discard = 0; end
      if (exp_issue) begin
        outstanding = 1;
        discard     = 0;
        req_addr_m  = pc_i;
        resp_at[cyc + lat] = $urandom;
        pc_i = pc_i + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 0; jump_flag_i = 0; hold_flag_i = '0; id_ready_i = 1;
    pc_i = '0; mem_rvalid_i = 0; mem_rdata_i = '0;
    @(posedge clk); #1;
    repeat (3) cycle();
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst",  inst_o, NOP);
    chk("rst_addr",  inst_addr_o, 32'h0);

    // Latency 1, decode always ready: one instruction per cycle.
    rst = 1; lat = 1; popped.delete(); req_count = 0;
    repeat (6) cycle();
    chk("l1_reqs", req_count, 6);
    chk("l1_n",    popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("l1_addr", popped[i], 32'(4 * i));

    // Latency 3: one request every third cycle.
    lat = 3; req_count = 0;
    repeat (9) cycle();
    chk("l3_reqs", req_count, 3);

    // Decode stalled: FIFO fills to DEPTH, then fetch stops.
    lat = 1; id_ready_i = 0; req_count = 0;
    repeat (6) cycle();
    chk("full_reqs",  req_count, 1);
    chk("full_valid", inst_valid_o, 1'b1);
    id_ready_i = 1; req_count = 0;
    repeat (6) cycle();
    chk("drain_reqs", req_count > 0, 1'b1);

    // Jump while a latency-3 request is in flight.
    lat = 3;
    for (int i = 0; i < 12 && !(outstanding && !resp_at.exists(cyc)); i++) cycle();
    jump_target = 32'h100; jump_flag_i = 1;
    cycle();
    jump_flag_i = 0; popped.delete();
    chk("jump_valid", inst_valid_o, 1'b0);
    repeat (10) cycle();
    chk("jump_n",    popped.size() > 0, 1'b1);
    chk("jump_addr", popped[0], 32'h100);

    // Hold for 4 cycles: no requests, in-flight data still delivered.
    hold_flag_i = 3'b010; req_count = 0;
    repeat (4) cycle();
    chk("hold_reqs", req_count, 0);
    hold_flag_i = 3'b000;
    repeat (4) cycle();

    // Reset in WAIT with one entry buffered; late response must be ignored.
    id_ready_i = 0; lat = 3;
    for (int i = 0; i < 16 && !(q.size() == 1 && outstanding && !resp_at.exists(cyc)); i++)
      cycle();
    chk("pre_rst_valid", inst_valid_o, 1'b1);
    rst = 0;
    cycle();
    chk("mid_rst_valid", inst_valid_o, 1'b0);
    chk("mid_rst_inst",  inst_o, NOP);
    rst = 1; hold_flag_i = 3'b010;
    repeat (2) cycle();
    chk("late_ignored", inst_valid_o, 1'b0);
    hold_flag_i = 3'b000; id_ready_i = 1; req_count = 0;
    cycle();
    chk("post_rst_req", req_count, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      id_ready_i  = ($urandom_range(0, 3) != 0);
      hold_flag_i = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 7))
                                                : 3'($urandom_range(0, 1));
      jump_flag_i = ($urandom_range(0, 19) == 0);
      jump_target = {$urandom_range(0, 32'hFFFF), 2'b00};
      lat = $urandom_range(1, 4);
      cycle();
    end
    jump_flag_i = 0; hold_flag_i = '0; id_ready_i = 1;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues single-outstanding read requests to instruction memory.
- Buffers returned instructions, with their addresses, in a small FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures the PC register via pc_hold_req_o, and flushes on jump.

Parameters:
- DEPTH, 2, instruction FIFO entries (power of two, >=2).
- NOP_INST, 32'h00000013, value driven on inst_o when the FIFO is empty.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; synchronous and active-low (0 = reset), sampled on the rising edge of clk.
- pc_i  input  32  current PC from the PC register.
- jump_flag_i  input  1  jump/flush request (1 = jump this cycle).
- hold_flag_i  input  3  pipeline hold level; values >= 3'b010 stall fetch.
- pc_hold_req_o  output  1  combinational; 1 = PC register must not advance this cycle.
- mem_req_o  output  1  combinational; 1-cycle read request strobe.
- mem_addr_o  output  32  combinational; equals pc_i.
- mem_rvalid_i  input  1  read data valid; at least 1 cycle after its request.
- mem_rdata_i  input  32  read data.
- inst_valid_o  output  1  FIFO head valid.
- inst_o  output  32  FIFO head instruction, or NOP_INST when empty.
- inst_addr_o  output  32  FIFO head address, or 0 when empty.
- id_ready_i  input  1  decode consumes the head when inst_valid_o is also 1.

Behaviour:
- State machine, 3 states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its address is held in req_addr.
  - DROP: one request outstanding whose data must be discarded.
- Memory accepts every request; there is no grant signal.
- Responses arriving in IDLE are ignored.
- pop = inst_valid_o & id_ready_i.
- push = state==WAIT & mem_rvalid_i & ~jump_flag_i. Pushes {req_addr, mem_rdata_i}.
- occ_next = count + push - pop. Simultaneous push and pop leave count unchanged.
- issue (mem_req_o) = rst & ~jump_flag_i & hold_flag_i < 3'b010 & (state==IDLE | mem_rvalid_i) & (occ_next < DEPTH).
  - The (state==IDLE | mem_rvalid_i) term allows back-to-back requests when a response arrives in the same cycle; this gives 1 instruction/cycle with 1-cycle memory.
- pc_hold_req_o = ~issue & ~jump_flag_i. During a jump the PC register loads the jump address regardless.
- On issue: req_addr <= pc_i and state <= WAIT.
- Response with no new issue: WAIT -> IDLE.
- DROP with mem_rvalid_i: data discarded. Next state is WAIT if issue, else IDLE.
- jump_flag_i=1 (highest priority after reset):
  - FIFO count <= 0; any push is suppressed; no issue.
  - If WAIT and no mem_rvalid_i this cycle, or already in DROP without rvalid: state <= DROP. Otherwise state <= IDLE.
  - inst_valid_o is 0 from the next cycle.
- Hold (hold_flag_i >= 3'b010):
  - No new issue.
  - An outstanding response is still pushed.
  - Output handshake is unaffected.
- Output latency: request in cycle N with response in cycle N+L gives inst_valid_o in cycle N+L+1.
- Outputs inst_o, inst_addr_o and inst_valid_o are read from registered FIFO storage, with no combinational path from mem_rdata_i.
- FIFO full: issue is blocked whenever occ_next == DEPTH; it can never overflow. Underflow is impossible because pop requires valid.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset (rst==0 at an edge):
  - state IDLE, count 0, pointers 0, req_addr 0.
  - inst_valid_o 0, inst_o NOP_INST, inst_addr_o 0.
  - While rst==0: mem_req_o 0 and pc_hold_req_o 1.
- Reset mid-request: the outstanding request is abandoned, and a late response arriving in IDLE is ignored.

Test Plan:
- Memory latency 1, id_ready_i=1, pc_i stepping 0,4,8,C -> mem_req_o high every cycle; inst_valid_o from cycle 2 with inst_addr_o 0,4,8,C consecutively; pc_hold_req_o stays 0.
- Memory latency 3 -> mem_req_o pulses once every 3 cycles; pc_hold_req_o=1 in the 2 cycles between pulses; each instruction appears 1 cycle after its rvalid.
- id_ready_i=0 with latency 1 -> exactly DEPTH=2 entries accepted; afterwards mem_req_o=0 and pc_hold_req_o=1. Raising id_ready_i drains 0, then 4, then fetch resumes.
- jump_flag_i=1 while a request for 8 is outstanding (latency 3), pc_i=0x100 next cycle -> FIFO empties, the response for 8 is discarded (DROP), and the next delivered inst_addr_o is 0x100.
- hold_flag_i=3'b010 for 4 cycles -> no mem_req_o during the hold; the in-flight response is still delivered; fetch resumes the cycle the hold drops.
- rst=0 asserted mid-WAIT with 1 entry buffered -> next cycle inst_valid_o=0 and inst_o=0x00000013; the late rvalid is ignored; after rst=1 the first request uses the current pc_i.
